imem_decomp: RTL
================

Name: imem_decomp

Overview:
- Dictionary-based instruction decompressor between the icache miss port and the compressed instruction store.
- Accepts icache line-fill word requests on the icache's mem_req handshake.
- Fetches a 16-bit token from a token table, then returns either a dictionary entry or a raw escaped word.
- Preserves random-access word addressing so the icache is unchanged.

Parameters:
- DICT_BITS, 8, log2 of dictionary entries (256 x 32-bit).
- INDEX_BASE, 32'h0001_0000, byte base of the token table in compressed memory.
- RAW_BASE, 32'h0004_0000, byte base of the escaped raw-word region.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  icache word request.
- req_ready  out  1  one-cycle response pulse.
- req_addr  in  32  byte address of the original instruction word.
- req_rdata  out  32  decompressed instruction; valid while req_ready=1.
- mem_valid  out  1  compressed-store request.
- mem_ready  in  1  compressed-store response pulse.
- mem_addr  out  32  compressed-store byte address, word aligned.
- mem_rdata  in  32  compressed-store read data.
- dict_we  in  1  dictionary write enable.
- dict_waddr  in  DICT_BITS  dictionary write index.
- dict_wdata  in  32  dictionary write data.
- dbg_escape  out  1  one-cycle pulse when a response came from the raw region.

Behaviour:
- Reset values: req_ready=0, req_rdata=0, mem_valid=0, mem_addr=0, dbg_escape=0, FSM=IDLE, token buffer invalid.
- The dictionary array is not reset.
- Address mapping:
  - Word index i = req_addr[31:2]; req_addr[1:0] is ignored.
  - Token word address = INDEX_BASE + ((i>>1)<<2). i[0]=0 selects token bits[15:0]; i[0]=1 selects bits[31:16].
- Token decode:
  - Bit15=1: dictionary token. Entry index = token[DICT_BITS-1:0]; token[14:DICT_BITS] is ignored.
  - Bit15=0: escape token. Raw word address = RAW_BASE + (token[14:0]<<2).
- Upstream handshake:
  - req_valid is held with req_addr stable until req_ready.
  - req_ready is high for exactly one cycle per request.
  - The block does not sample a new request in the cycle req_ready is high.
  - Deasserting req_valid before req_ready is illegal; behaviour is unspecified.
- Downstream handshake:
  - mem_valid and mem_addr are held until mem_ready.
  - mem_valid drops in the cycle after mem_ready is sampled.
  - At most one outstanding request.
- FSM:
  - IDLE: on req_valid, latch the address and go to FETCH_TOK (mem_valid=1 from the next cycle).
  - FETCH_TOK: on mem_ready, capture the token word. Dictionary token -> LOOKUP. Escape token -> FETCH_RAW.
  - LOOKUP: read the dictionary (registered) and go to RESP.
  - FETCH_RAW: on mem_ready, capture the raw word, set dbg_escape for the RESP cycle, go to RESP.
  - RESP: req_ready=1 with req_rdata, then IDLE.
- Latency from req_valid to req_ready, with zero-wait memory (mem_ready in the first cycle mem_valid is high):
  - Dictionary hit: 4 cycles.
  - Escape: 5 cycles.
  - Each memory wait cycle adds 1.
- Dictionary write: takes effect at the next edge and is accepted in any state. When a write and a LOOKUP read hit the same index in the same cycle, the read returns the old value.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with all outputs at reset values.
  - Any pending mem_ready is ignored.
  - The upstream must reissue.

Optional Feature:
- Macro: DECOMP_TOKBUF_EN.
- Defined:
  - Adds a one-entry token-word buffer holding {tag = token word address, 32-bit data, valid}.
  - In IDLE, a request whose token word address matches the valid tag skips FETCH_TOK and goes straight to token decode: LOOKUP for a dictionary token, FETCH_RAW for an escape.
  - Buffered dictionary hit latency: 3 cycles.
  - The buffer is filled on every FETCH_TOK completion and invalidated by reset.
- Undefined: no buffer; every request performs FETCH_TOK.

Test Plan:
- Dictionary hit:
  - Setup: dict[5]=32'h0000_0013; token word at 0x10000 = 32'h0000_8005.
  - Stimulus: req_addr=0x0, zero-wait memory.
  - Required: one mem access at 0x10000; req_ready at cycle 4; req_rdata=0x00000013; dbg_escape=0.
- Escape:
  - Setup: token word at 0x10000 = 32'h0003_8005; raw word at 0x4000C = 32'hDEAD_BEEF.
  - Stimulus: req_addr=0x4.
  - Required: mem accesses 0x10000 then 0x4000C; req_rdata=0xDEADBEEF; dbg_escape pulses once.
- Wait states: memory inserts 3 wait cycles per access on a dictionary hit -> req_ready at cycle 7; mem_addr stable throughout the wait.
- Reset mid-FETCH_RAW:
  - Stimulus: assert reset while mem_valid=1, drive mem_ready afterwards.
  - Required: mem_valid=0 immediately; no req_ready; the next request completes normally.
- Dictionary write collision: dict_we to index 5 (value 0x1) in the LOOKUP cycle of a hit on index 5 -> response returns the old value; a repeat request returns 0x1.
- DECOMP_TOKBUF_EN: requests 0x0 then 0x4 (same token word) -> the second request makes no FETCH_TOK access; a dictionary-hit second response arrives at cycle 3.

Source files
------------

// File: rtl/imem_decomp.sv
// imem_decomp: dictionary-based instruction decompressor sitting between the
// icache miss port and the compressed instruction store. Each word request
// fetches a 16-bit token, then returns either a dictionary entry or a raw
// escaped word from the raw region.
// Build option: define DECOMP_TOKBUF_EN to add a one-entry token-word buffer
// that lets a request sharing the previous token word skip the token fetch.
module imem_decomp #(
    parameter int          DICT_BITS  = 8,
    parameter logic [31:0] INDEX_BASE = 32'h0001_0000,
    parameter logic [31:0] RAW_BASE   = 32'h0004_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    output logic [31:0]          req_rdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [31:0]          mem_addr,
    input  logic [31:0]          mem_rdata,
    input  logic                 dict_we,
    input  logic [DICT_BITS-1:0] dict_waddr,
    input  logic [31:0]          dict_wdata,
    output logic                 dbg_escape
);

    localparam int DICT_SIZE = 1 << DICT_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_TOK,
        S_LOOKUP,
        S_FETCH_RAW,
        S_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic        mem_valid_reg, mem_valid_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic        sel_reg, sel_next;        // which token half the request uses
    logic [14:0] tok_reg, tok_next;        // token payload (bit 15 consumed at decode)
    logic [31:0] raw_reg, raw_next;
    logic        esc_reg, esc_next;        // response comes from the raw region

    logic [31:0] dict_mem [DICT_SIZE];
    logic [31:0] dict_q;

    logic [31:0] req_tok_addr;
    logic [15:0] cap_tok;
    logic [31:0] raw_addr;

    // Byte offset within a word never matters: the store is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    // Two tokens share one 32-bit token word, so the word index is halved.
    assign req_tok_addr = INDEX_BASE + {1'b0, req_addr[31:3], 2'b00};
    assign cap_tok      = sel_reg ? mem_rdata[31:16] : mem_rdata[15:0];
    assign raw_addr     = RAW_BASE + {15'd0, tok_reg, 2'b00};

`ifdef DECOMP_TOKBUF_EN
    logic        buf_valid_reg, buf_valid_next;
    logic [31:0] buf_tag_reg, buf_tag_next;
    logic [31:0] buf_data_reg, buf_data_next;
    logic [15:0] buf_tok;
    logic        buf_hit;

    assign buf_tok = req_addr[2] ? buf_data_reg[31:16] : buf_data_reg[15:0];
    assign buf_hit = buf_valid_reg && (buf_tag_reg == req_tok_addr);
`endif

    // Dictionary: write any time, registered read only in LOOKUP (old data on collision).
    always_ff @(posedge clk) begin
        if (dict_we) begin
            dict_mem[dict_waddr] <= dict_wdata;
        end
        if (state_reg == S_LOOKUP) begin
            dict_q <= dict_mem[tok_reg[DICT_BITS-1:0]];
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            mem_valid_reg <= 1'b0;
            mem_addr_reg  <= 32'd0;
            sel_reg       <= 1'b0;
            tok_reg       <= 15'd0;
            raw_reg       <= 32'd0;
            esc_reg       <= 1'b0;
`ifdef DECOMP_TOKBUF_EN
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= 32'd0;
            buf_data_reg  <= 32'd0;
`endif
        end else begin
            state_reg     <= state_next;
            mem_valid_reg <= mem_valid_next;
            mem_addr_reg  <= mem_addr_next;
            sel_reg       <= sel_next;
            tok_reg       <= tok_next;
            raw_reg       <= raw_next;
            esc_reg       <= esc_next;
`ifdef DECOMP_TOKBUF_EN
            buf_valid_reg <= buf_valid_next;
            buf_tag_reg   <= buf_tag_next;
            buf_data_reg  <= buf_data_next;
`endif
        end
    end

    // Next-state logic: token fetch, decode, then dictionary read or raw fetch.
    always_comb begin
        state_next     = state_reg;
        mem_valid_next = mem_valid_reg;
        mem_addr_next  = mem_addr_reg;
        sel_next       = sel_reg;
        tok_next       = tok_reg;
        raw_next       = raw_reg;
        esc_next       = esc_reg;
`ifdef DECOMP_TOKBUF_EN
        buf_valid_next = buf_valid_reg;
        buf_tag_next   = buf_tag_reg;
        buf_data_next  = buf_data_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    sel_next = req_addr[2];
                    esc_next = 1'b0;
`ifdef DECOMP_TOKBUF_EN
                    if (buf_hit) begin
                        tok_next   = buf_tok[14:0];
                        state_next = buf_tok[15] ? S_LOOKUP : S_FETCH_RAW;
                    end else begin
                        mem_valid_next = 1'b1;
                        mem_addr_next  = req_tok_addr;
                        state_next     = S_FETCH_TOK;
                    end
`else
                    mem_valid_next = 1'b1;
                    mem_addr_next  = req_tok_addr;
                    state_next     = S_FETCH_TOK;
`endif
                end
            end
            S_FETCH_TOK: begin
                if (mem_ready) begin
                    mem_valid_next = 1'b0;
                    tok_next       = cap_tok[14:0];
                    state_next     = cap_tok[15] ? S_LOOKUP : S_FETCH_RAW;
`ifdef DECOMP_TOKBUF_EN
                    buf_valid_next = 1'b1;
                    buf_tag_next   = mem_addr_reg;
                    buf_data_next  = mem_rdata;
`endif
                end
            end
            S_LOOKUP: begin
                state_next = S_RESP;
            end
            S_FETCH_RAW: begin
                // First cycle issues the raw read so mem_valid has a gap after the token read.
                if (!mem_valid_reg) begin
                    mem_valid_next = 1'b1;
                    mem_addr_next  = raw_addr;
                end else if (mem_ready) begin
                    mem_valid_next = 1'b0;
                    raw_next       = mem_rdata;
                    esc_next       = 1'b1;
                    state_next     = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_reg == S_RESP);
    assign dbg_escape = req_ready && esc_reg;
    assign req_rdata  = !req_ready ? 32'd0 : (esc_reg ? raw_reg : dict_q);
    assign mem_valid  = mem_valid_reg;
    assign mem_addr   = mem_addr_reg;

endmodule
